// File: rtl/uart_cmd_controller.sv
// Parses SYNC/CMD/DATA/CHK write frames from the UART receiver byte stream.
// Valid frames update an 8x8 register file; errors are pulsed and counted.
module uart_cmd_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 27800,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [63:0] reg_file,
  output logic        wr_stb,
  output logic [2:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_ok,
  output logic        err_chk,
  output logic        err_cmd,
  output logic        err_timeout,
  output logic [7:0]  err_count,
  output logic [1:0]  state
);

  // state    | meaning
  // IDLE     | hunting for SYNC_BYTE, other bytes dropped
  // GET_CMD  | next byte is the command
  // GET_DATA | next byte is the data
  // GET_CHK  | next byte is the checksum, frame resolves here
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GET_CMD  = 2'd1,
    S_GET_DATA = 2'd2,
    S_GET_CHK  = 2'd3
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] cnt_q, cnt_d;
  logic        do_write, do_clear;
  logic        ev_chk, ev_cmd, ev_to;
  logic        chk_good;

  assign chk_good = (rx_data == (SYNC_BYTE ^ cmd_q ^ data_q));

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    do_write = 1'b0;
    do_clear = 1'b0;
    ev_chk   = 1'b0;
    ev_cmd   = 1'b0;
    ev_to    = 1'b0;
    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == SYNC_BYTE) state_d = S_GET_CMD;
        end
        S_GET_CMD: begin
          cmd_d   = rx_data;
          state_d = S_GET_DATA;
        end
        S_GET_DATA: begin
          data_d  = rx_data;
          state_d = S_GET_CHK;
        end
        S_GET_CHK: begin
          state_d = S_IDLE;
          if (!chk_good)            ev_chk   = 1'b1;
          else if (cmd_q[7])        do_write = 1'b1;
          else if (cmd_q == 8'h00)  do_clear = 1'b1;
          else                      ev_cmd   = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end else if ((state_q != S_IDLE) && (cnt_q == TO_LAST)) begin
      // a byte arriving in the terminal cycle takes priority over the timeout
      state_d = S_IDLE;
      ev_to   = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (rx_valid || (state_q == S_IDLE)) cnt_d = 16'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= 8'h00;
      data_q      <= 8'h00;
      cnt_q       <= 16'd0;
      reg_file    <= 64'd0;
      wr_stb      <= 1'b0;
      wr_addr     <= 3'd0;
      wr_data     <= 8'h00;
      frame_ok    <= 1'b0;
      err_chk     <= 1'b0;
      err_cmd     <= 1'b0;
      err_timeout <= 1'b0;
      err_count   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      wr_stb      <= do_write;
      frame_ok    <= do_write | do_clear;
      err_chk     <= ev_chk;
      err_cmd     <= ev_cmd;
      err_timeout <= ev_to;
      if (do_write) begin
        reg_file[{cmd_q[2:0], 3'b000} +: 8] <= data_q;
        wr_addr <= cmd_q[2:0];
        wr_data <= data_q;
      end
      if (do_clear) reg_file <= 64'd0;
      if ((ev_chk | ev_cmd | ev_to) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Randomized scoreboard bench for uart_cmd_controller; a frame-level model
// predicts every output pulse with its cycle and the resulting register state.
module tb_uart_cmd_controller;
  localparam int         TO   = 20;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [63:0] reg_file;
  logic        wr_stb;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        frame_ok;
  logic        err_chk;
  logic        err_cmd;
  logic        err_timeout;
  logic [7:0]  err_count;
  logic [1:0]  state;

  always #5 clk = ~clk;

  uart_cmd_controller #(.TIMEOUT_CYCLES(TO), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .reg_file(reg_file), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_ok(frame_ok), .err_chk(err_chk), .err_cmd(err_cmd),
    .err_timeout(err_timeout), .err_count(err_count), .state(state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 write, 1 clear, 2 checksum error, 3 command error, 4 timeout
  typedef struct {
    int          kind;
    int          cyc;
    logic [63:0] rf;
    int          ec;
    logic [2:0]  wa;
    logic [7:0]  wd;
  } ev_t;

  ev_t exq[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  logic [7:0] m_regs [8];
  int         m_ec;
  logic [2:0] m_wa;
  logic [7:0] m_wd;
  logic [7:0] fq[$];
  int         tp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pack_regs();
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = m_regs[k];
    return r;
  endfunction

  task automatic push_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind; e.cyc = c; e.rf = pack_regs();
    e.ec = m_ec; e.wa = m_wa; e.wd = m_wd;
    exq.push_back(e);
  endtask

  task automatic add_err();
    if (m_ec < 255) m_ec++;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_regs[k] = 8'h00;
    m_ec = 0; m_wa = 3'd0; m_wd = 8'h00;
    fq.delete();
  endtask

  // byte driven at negedge t is sampled by edge t+1; its effects are seen at cycle t+1
  task automatic model_byte(input logic [7:0] b, input int t);
    logic [7:0] c, d, k;
    tp = t;
    if (fq.size() == 0) begin
      if (b == SYNC) fq.push_back(b);
    end else begin
      fq.push_back(b);
      if (fq.size() == 4) begin
        c = fq[1]; d = fq[2]; k = fq[3];
        if (k != (SYNC ^ c ^ d)) begin
          add_err(); push_ev(2, t + 1);
        end else if (c[7]) begin
          m_regs[c[2:0]] = d; m_wa = c[2:0]; m_wd = d; push_ev(0, t + 1);
        end else if (c == 8'h00) begin
          for (int j = 0; j < 8; j++) m_regs[j] = 8'h00;
          push_ev(1, t + 1);
        end else begin
          add_err(); push_ev(3, t + 1);
        end
        fq.delete();
      end
    end
  endtask

  // no byte at edge t+1: a partial frame expires TO cycles after its last byte
  task automatic model_idle(input int t);
    if ((fq.size() != 0) && (t - tp == TO)) begin
      add_err(); push_ev(4, t + 1); fq.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      rx_valid = 1'b0;
      model_idle(cyc);
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    idle(gap);
    model_byte(b, cyc);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d, input int gap);
    send(a, gap); send(b, 0); send(c, 0); send(d, 0);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic int rgap();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return $urandom_range(0, 2);
    if (r < 8) return $urandom_range(3, 10);
    return $urandom_range(TO - 2, TO + 2);
  endfunction

  always @(posedge clk) begin : monitor
    ev_t e;
    int  k;
    #2;
    if (mon_en) begin
      while ((exq.size() > 0) && (exq[0].cyc < cyc)) begin
        checks++; errors++;
        $display("FAIL missed_event: kind %0d due cycle %0d, not observed by cycle %0d",
                 exq[0].kind, exq[0].cyc, cyc);
        void'(exq.pop_front());
      end
      if (wr_stb | frame_ok | err_chk | err_cmd | err_timeout) begin
        case ({wr_stb, frame_ok, err_chk, err_cmd, err_timeout})
          5'b11000: k = 0;
          5'b01000: k = 1;
          5'b00100: k = 2;
          5'b00010: k = 3;
          5'b00001: k = 4;
          default:  k = 7;
        endcase
        if (exq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: pulses %b at cycle %0d, nothing expected",
                   {wr_stb, frame_ok, err_chk, err_cmd, err_timeout}, cyc);
        end else begin
          e = exq.pop_front();
          check("ev_kind", k, e.kind);
          check("ev_cycle", cyc, e.cyc);
          check("ev_reg_file", reg_file, e.rf);
          check("ev_err_count", err_count, e.ec);
          check("ev_wr_addr", wr_addr, e.wa);
          check("ev_wr_data", wr_data, e.wd);
          check("ev_state", state, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] c, d, ck;
    int         t, n;
    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    tp = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("rst_state", state, 0);
    check("rst_reg_file", reg_file, 0);
    check("rst_err_count", err_count, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_pulses", {wr_stb, frame_ok, err_chk, err_cmd, err_timeout}, 0);
    mon_en = 1'b1;

    frame(8'hA5, 8'h81, 8'h3C, 8'h18, 0);
    idle(2);
    check("write_reg1", reg_file[15:8], 8'h3C);
    frame(8'hA5, 8'h87, 8'hFF, 8'hDD, 1);
    idle(1);
    check("write_reg7", reg_file[63:56], 8'hFF);
    frame(8'hA5, 8'h00, 8'h55, 8'hF0, 0);
    idle(1);
    check("clear_all", reg_file, 0);
    frame(8'hA5, 8'h82, 8'h10, 8'h00, 2);
    frame(8'hA5, 8'h05, 8'h11, 8'hB1, 0);
    idle(1);
    check("err_count_two", err_count, 2);

    send(8'hA5, 3); send(8'h83, 0);
    idle(TO + 5);
    frame(8'hA5, 8'h84, 8'h77, 8'h56, 0);
    idle(1);
    check("after_timeout_reg4", reg_file[39:32], 8'h77);

    send(8'h12, 1); send(8'h34, 0); send(8'hA5, 0); send(8'h81, 0);
    idle(1);
    do_reset();
    send(8'h3C, 0); send(8'h18, 0);
    idle(2);
    check("reset_mid_frame_regs", reg_file, 0);
    check("reset_mid_frame_errs", err_count, 0);
    frame(8'hA5, 8'h81, 8'h3C, 8'h18, 0);

    // timeout boundary: a byte exactly at the limit wins, one cycle later it is too late
    send(8'hA5, 2); send(8'h86, 0); send(8'h42, TO - 1); send(8'hA5 ^ 8'h86 ^ 8'h42, 0);
    send(8'hA5, 2); send(8'h81, TO);
    idle(3);
    check("boundary_reg6", reg_file[55:48], 8'h42);

    for (int i = 0; i < 60; i++) begin
      t = $urandom_range(0, 9);
      c = 8'($urandom); d = 8'($urandom);
      if (t < 4) begin
        c[7] = 1'b1;
        frame(SYNC, c, d, SYNC ^ c ^ d, rgap());
      end else if (t == 4) begin
        frame(SYNC, 8'h00, d, SYNC ^ d, rgap());
      end else if (t == 5) begin
        ck = (SYNC ^ c ^ d) ^ (8'd1 << $urandom_range(0, 7));
        frame(SYNC, c, d, ck, rgap());
      end else if (t == 6) begin
        c[7] = 1'b0;
        if (c == 8'h00) c = 8'h41;
        frame(SYNC, c, d, SYNC ^ c ^ d, rgap());
      end else if (t == 7) begin
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) send(8'($urandom), rgap());
      end else begin
        c[7] = 1'b1;
        send(SYNC, rgap()); send(c, rgap()); send(d, rgap()); send(SYNC ^ c ^ d, rgap());
      end
    end

    for (int i = 0; i < 260; i++) frame(8'hA5, 8'h81, 8'h3C, 8'h00, 0);
    idle(TO + 5);
    check("queue_drained", exq.size(), 0);
    check("err_count_saturated", err_count, 8'hFF);
    check("final_state", state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
